// File: rtl/i2s_rec_deserializer.sv
// i2s_rec_deserializer: oversampled I2S record receiver packing {L,R} frames into a FWFT FIFO with valid/ready output
module i2s_rec_deserializer #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic board_clk,
   input  logic reset,
   input  logic ac_bclk,
   input  logic ac_reclrc,
   input  logic ac_recdat,
   input  logic enable,
   output logic [2*SAMPLE_WIDTH-1:0] rec_tdata,
   output logic rec_tvalid,
   input  logic rec_tready,
   output logic overflow,
   output logic frame_err,
   input  logic err_clr
);
   localparam int SW = SAMPLE_WIDTH;
   localparam int BW = $clog2(SW + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   typedef enum logic [1:0] {WAIT_SYNC, SHIFT, PAD} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] bclk_q, lrc_q, dat_q;
   logic bclk_d, lrc_s, bclk_rise, lrc_edge, sync_lrc, sync_dat;
   logic chan, chan_n, shift_en, ferr_set, push, pop, wr_en, full;
   logic [BW-1:0] bitcnt, bitcnt_n;
   logic [SW-1:0] left_q, right_q;
   logic [2*SW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   assign sync_lrc = lrc_q[SYNC_STAGES-1];
   assign sync_dat = dat_q[SYNC_STAGES-1];
   assign bclk_rise = bclk_q[SYNC_STAGES-1] & ~bclk_d;
   assign lrc_edge = sync_lrc != lrc_s;
   assign rec_tdata = mem[rd_ptr];
   assign rec_tvalid = count != '0;
   assign full = count == CW'(FIFO_DEPTH);
   assign pop = rec_tvalid & rec_tready;
   assign wr_en = push & (~full | pop);
   // synchronize the codec lines and remember LRCLK as seen at the previous BCLK rise
   always_ff @(posedge board_clk) begin
      if (reset) begin
         bclk_q <= '0;
         lrc_q <= '0;
         dat_q <= '0;
         bclk_d <= 1'b0;
         lrc_s <= 1'b0;
      end else begin
         bclk_q <= {bclk_q[SYNC_STAGES-2:0], ac_bclk};
         lrc_q <= {lrc_q[SYNC_STAGES-2:0], ac_reclrc};
         dat_q <= {dat_q[SYNC_STAGES-2:0], ac_recdat};
         bclk_d <= bclk_q[SYNC_STAGES-1];
         if (bclk_rise) lrc_s <= sync_lrc;
      end
   end
   // slot tracking: an LRCLK edge marks the delay bit, the next SW rises are MSB..LSB
   always_comb begin
      state_n = state;
      chan_n = chan;
      bitcnt_n = bitcnt;
      shift_en = 1'b0;
      ferr_set = 1'b0;
      push = 1'b0;
      if (!enable) state_n = WAIT_SYNC;
      else if (bclk_rise) begin
         case (state)
            WAIT_SYNC: if (lrc_edge && !sync_lrc) begin
               state_n = SHIFT;
               chan_n = 1'b0;
               bitcnt_n = '0;
            end
            SHIFT: if (lrc_edge) begin
               ferr_set = 1'b1;
               state_n = sync_lrc ? WAIT_SYNC : SHIFT;
               chan_n = 1'b0;
               bitcnt_n = '0;
            end else begin
               shift_en = 1'b1;
               bitcnt_n = bitcnt + BW'(1);
               if (bitcnt == BW'(SW - 1)) state_n = PAD;
            end
            PAD: if (lrc_edge) begin
               bitcnt_n = '0;
               if (!chan && sync_lrc) begin
                  state_n = SHIFT;
                  chan_n = 1'b1;
               end else if (chan && !sync_lrc) begin
                  push = 1'b1;
                  state_n = SHIFT;
                  chan_n = 1'b0;
               end else begin
                  ferr_set = 1'b1;
                  state_n = WAIT_SYNC;
               end
            end
            default: state_n = WAIT_SYNC;
         endcase
      end
   end
   // FSM state, channel/bit counters and per-channel shift registers
   always_ff @(posedge board_clk) begin
      if (reset) begin
         state <= WAIT_SYNC;
         chan <= 1'b0;
         bitcnt <= '0;
         left_q <= '0;
         right_q <= '0;
      end else begin
         state <= state_n;
         chan <= chan_n;
         bitcnt <= bitcnt_n;
         if (shift_en && chan) right_q <= {right_q[SW-2:0], sync_dat};
         if (shift_en && !chan) left_q <= {left_q[SW-2:0], sync_dat};
      end
   end
   // first-word-fall-through frame FIFO; a pop in the same cycle makes room for a push when full
   always_ff @(posedge board_clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) mem[wr_ptr] <= {left_q, right_q};
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(wr_en) - CW'(pop);
      end
   end
   // sticky error flags; a new error wins over a simultaneous clear
   always_ff @(posedge board_clk) begin
      if (reset) begin
         overflow <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow <= (push & ~wr_en) | (overflow & ~err_clr);
         frame_err <= ferr_set | (frame_err & ~err_clr);
      end
   end
endmodule

// File: tb/tb_i2s_rec_deserializer.sv
// tb_i2s_rec_deserializer: vector table plus scoreboard-checked I2S record sequences
`timescale 1ns/1ps
module tb_i2s_rec_deserializer;
   logic board_clk = 1'b0;
   logic reset, ac_bclk, ac_reclrc, ac_recdat, enable, rec_tready, err_clr;
   logic [47:0] rec_tdata;
   logic rec_tvalid, overflow, frame_err;
   int total = 0;
   int bad = 0;
   logic [47:0] exp_q[$];
   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int len;
      logic [47:0] exp;
   } vec_t;
   vec_t vecs[5];

   i2s_rec_deserializer dut (
      .board_clk(board_clk), .reset(reset), .ac_bclk(ac_bclk), .ac_reclrc(ac_reclrc),
      .ac_recdat(ac_recdat), .enable(enable), .rec_tdata(rec_tdata), .rec_tvalid(rec_tvalid),
      .rec_tready(rec_tready), .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #5 board_clk = ~board_clk;

   function automatic void check(string name, logic [47:0] act, logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // scoreboard: every accepted beat must be the oldest expected frame
   always @(negedge board_clk) begin
      if (!reset && rec_tvalid && rec_tready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop: unexpected frame %h", rec_tdata);
         end else check("pop", rec_tdata, exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic clocks(input int n);
      repeat (n) @(posedge board_clk);
      #1;
   endtask

   task automatic send_bit(input logic lrc, input logic dat);
      ac_bclk = 1'b0;
      ac_reclrc = lrc;
      ac_recdat = dat;
      clocks(4);
      ac_bclk = 1'b1;
      clocks(4);
   endtask

   task automatic send_slot(input logic lrc, input logic [23:0] d, input int len);
      for (int i = 0; i < len; i++)
         send_bit(lrc, (i >= 1 && i <= 24) ? d[24-i] : 1'($urandom));
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int len);
      send_slot(1'b0, l, len);
      send_slot(1'b1, r, len);
   endtask

   task automatic tail(input bit pop_at_push);
      ac_bclk = 1'b0;
      ac_reclrc = 1'b0;
      ac_recdat = 1'($urandom);
      clocks(4);
      ac_bclk = 1'b1;
      if (pop_at_push) begin
         clocks(2);
         rec_tready = 1'b1;
         clocks(1);
         rec_tready = 1'b0;
         clocks(1);
      end else clocks(4);
      send_slot(1'b0, 24'h0, 3);
      enable = 1'b0;
      send_slot(1'b1, 24'h0, 8);
      enable = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) clocks(1);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      vecs[0] = '{24'hABCDEF, 24'h123456, 32, 48'hABCDEF123456};
      vecs[1] = '{24'h000000, 24'hFFFFFF, 32, 48'h000000FFFFFF};
      vecs[2] = '{24'hFFFFFF, 24'h000000, 25, 48'hFFFFFF000000};
      vecs[3] = '{24'h800001, 24'h7FFFFE, 48, 48'h8000017FFFFE};
      vecs[4] = '{24'h5A5A5A, 24'hA5A5A5, 32, 48'h5A5A5AA5A5A5};
      reset = 1'b1;
      ac_bclk = 1'b0;
      ac_reclrc = 1'b0;
      ac_recdat = 1'b0;
      enable = 1'b1;
      rec_tready = 1'b1;
      err_clr = 1'b0;
      clocks(4);
      reset = 1'b0;
      @(negedge board_clk);
      check("reset_tvalid", rec_tvalid, 0);
      check("reset_tdata", rec_tdata, 0);
      check("reset_overflow", overflow, 0);
      check("reset_frame_err", frame_err, 0);
      send_slot(1'b1, 24'h0, 8);

      for (int v = 0; v < 5; v++) begin
         exp_q.push_back(vecs[v].exp);
         send_frame(vecs[v].l, vecs[v].r, vecs[v].len);
      end
      tail(0);
      wait_drain("vec_drain");
      check("vec_overflow", overflow, 0);
      check("vec_frame_err", frame_err, 0);

      rec_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) exp_q.push_back({24'hA00000 + 24'(k), 24'h0B0000 + 24'(k)});
         send_frame(24'hA00000 + 24'(k), 24'h0B0000 + 24'(k), 32);
      end
      @(negedge board_clk);
      check("full_tvalid", rec_tvalid, 1);
      check("full_head", rec_tdata, 48'hA000000B0000);
      check("full_no_overflow_yet", overflow, 0);
      tail(0);
      @(negedge board_clk);
      check("overflow_set", overflow, 1);
      rec_tready = 1'b1;
      wait_drain("ovf_drain");
      @(negedge board_clk);
      check("ovf_empty", rec_tvalid, 0);
      check("ovf_sticky", overflow, 1);
      #1;
      err_clr = 1'b1;
      clocks(1);
      err_clr = 1'b0;
      @(negedge board_clk);
      check("overflow_cleared", overflow, 0);
      check("ovf_frame_err", frame_err, 0);

      send_slot(1'b0, 24'hFFFF00, 16);
      send_slot(1'b1, 24'h111111, 32);
      exp_q.push_back(48'h5A5A5AC3C3C3);
      send_frame(24'h5A5A5A, 24'hC3C3C3, 32);
      tail(0);
      wait_drain("short_drain");
      check("short_frame_err", frame_err, 1);

      enable = 1'b0;
      send_slot(1'b0, 24'h777777, 32);
      send_slot(1'b1, 24'h999999, 12);
      enable = 1'b1;
      send_slot(1'b1, 24'h999999, 20);
      exp_q.push_back(48'h000001800000);
      send_frame(24'h000001, 24'h800000, 32);
      tail(0);
      wait_drain("midright_drain");

      send_slot(1'b0, 24'hDEAD00, 12);
      enable = 1'b0;
      send_slot(1'b0, 24'hDEAD00, 4);
      enable = 1'b1;
      send_slot(1'b0, 24'hDEAD00, 16);
      send_slot(1'b1, 24'hBEEF00, 32);
      exp_q.push_back(48'h13579B2468AC);
      send_frame(24'h13579B, 24'h2468AC, 32);
      tail(0);
      wait_drain("enable_drain");

      rec_tready = 1'b0;
      exp_q.push_back(48'h0F0F0FF0F0F0);
      send_frame(24'h0F0F0F, 24'hF0F0F0, 32);
      send_slot(1'b0, 24'h333333, 10);
      @(negedge board_clk);
      check("pre_reset_tvalid", rec_tvalid, 1);
      check("pre_reset_frame_err", frame_err, 1);
      #1;
      reset = 1'b1;
      clocks(1);
      reset = 1'b0;
      exp_q.delete();
      @(negedge board_clk);
      check("midshift_reset_tvalid", rec_tvalid, 0);
      check("midshift_reset_tdata", rec_tdata, 0);
      check("midshift_reset_overflow", overflow, 0);
      check("midshift_reset_frame_err", frame_err, 0);
      #1;
      send_slot(1'b1, 24'h0, 8);

      for (int k = 0; k < 5; k++) begin
         exp_q.push_back({24'hC00000 + 24'(k), 24'h0D0000 + 24'(k)});
         send_frame(24'hC00000 + 24'(k), 24'h0D0000 + 24'(k), 32);
      end
      tail(1);
      @(negedge board_clk);
      check("pushpop_full_overflow", overflow, 0);
      check("pushpop_full_left", exp_q.size(), 4);
      check("pushpop_full_head", rec_tdata, 48'hC000010D0001);
      rec_tready = 1'b1;
      wait_drain("pushpop_drain");

      for (int k = 0; k < 100; k++) begin
         logic [23:0] l, r;
         l = 24'($urandom);
         r = 24'($urandom);
         exp_q.push_back({l, r});
         send_frame(l, r, 25);
      end
      tail(0);
      wait_drain("random_drain");
      check("random_overflow", overflow, 0);
      check("random_frame_err", frame_err, 0);
      @(negedge board_clk);
      check("random_empty", rec_tvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
